// File: rtl/tx_frame_arbiter.sv
// Frame-granular two-port AXI-Stream arbiter feeding the SimpleMac transmit path.
// Forwards one whole frame at a time and aborts frames whose source stalls.
module tx_frame_arbiter #(
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter bit          STRICT_PRIO   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_tdata,
  input  logic       s0_tvalid,
  input  logic       s0_tlast,
  input  logic       s0_tuser,
  output logic       s0_tready,
  input  logic [7:0] s1_tdata,
  input  logic       s1_tvalid,
  input  logic       s1_tlast,
  input  logic       s1_tuser,
  output logic       s1_tready,
  output logic [7:0] tx_tdata,
  output logic       tx_tvalid,
  output logic       tx_tlast,
  output logic       tx_tuser,
  input  logic       tx_tready,
  input  logic       tx_a_full,
  output logic       grant,
  output logic [15:0] frame_cnt0,
  output logic [15:0] frame_cnt1,
  output logic [7:0] abort_cnt,
  output logic       busy
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned ABORT_W = 8;
  localparam int unsigned STALL_W = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_ABORT,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0]   frame_cnt0_q, frame_cnt0_d;
  logic [CNT_W-1:0]   frame_cnt1_q, frame_cnt1_d;
  logic [ABORT_W-1:0] abort_cnt_q, abort_cnt_d;

  // Granted-port view of the source signals
  logic [DATA_W-1:0] sel_tdata;
  logic              sel_tvalid;
  logic              sel_tlast;
  logic              sel_tuser;

  always_comb begin
    sel_tdata  = grant_q ? s1_tdata  : s0_tdata;
    sel_tvalid = grant_q ? s1_tvalid : s0_tvalid;
    sel_tlast  = grant_q ? s1_tlast  : s0_tlast;
    sel_tuser  = grant_q ? s1_tuser  : s0_tuser;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      stall_q      <= '0;
      frame_cnt0_q <= '0;
      frame_cnt1_q <= '0;
      abort_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
      frame_cnt0_q <= frame_cnt0_d;
      frame_cnt1_q <= frame_cnt1_d;
      abort_cnt_q  <= abort_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    stall_d      = stall_q;
    frame_cnt0_d = frame_cnt0_q;
    frame_cnt1_d = frame_cnt1_q;
    abort_cnt_d  = abort_cnt_q;
    tx_tdata     = '0;
    tx_tvalid    = 1'b0;
    tx_tlast     = 1'b0;
    tx_tuser     = 1'b0;
    s0_tready    = 1'b0;
    s1_tready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_d = '0;
        if (!tx_a_full && (s0_tvalid || s1_tvalid)) begin
          state_d = S_PASS;
          if (s0_tvalid && s1_tvalid) begin
            grant_d = STRICT_PRIO ? 1'b1 : ~last_grant_q;
          end else begin
            grant_d = s1_tvalid;
          end
        end
      end

      S_PASS: begin
        tx_tdata  = sel_tdata;
        tx_tvalid = sel_tvalid;
        tx_tlast  = sel_tlast;
        tx_tuser  = sel_tuser;
        if (grant_q) s1_tready = tx_tready;
        else         s0_tready = tx_tready;
        if (sel_tvalid && tx_tready) begin
          stall_d = '0;
          if (sel_tlast) begin
            if (grant_q) frame_cnt1_d = frame_cnt1_q + CNT_W'(1);
            else         frame_cnt0_d = frame_cnt0_q + CNT_W'(1);
            last_grant_d = grant_q;
            state_d      = S_IDLE;
          end
        end else if (!sel_tvalid) begin
          // MAC backpressure holds the counter; only source silence counts
          stall_d = stall_q + STALL_W'(1);
          if (stall_d == STALL_W'(STALL_TIMEOUT)) state_d = S_ABORT;
        end
      end

      S_ABORT: begin
        tx_tvalid = 1'b1;
        tx_tlast  = 1'b1;
        tx_tuser  = 1'b1;
        if (tx_tready) begin
          stall_d = '0;
          if (abort_cnt_q != '1) abort_cnt_d = abort_cnt_q + ABORT_W'(1);
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (grant_q) s1_tready = 1'b1;
        else         s0_tready = 1'b1;
        if (sel_tvalid && sel_tlast) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign grant      = grant_q;
  assign frame_cnt0 = frame_cnt0_q;
  assign frame_cnt1 = frame_cnt1_q;
  assign abort_cnt  = abort_cnt_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: a round-robin instance and a strict-priority
// instance share stimulus; queue-based sources follow the selected instance's tready.
module tb_tx_frame_arbiter;

  logic       clk, rst;
  logic [7:0] s0_tdata, s1_tdata;
  logic       s0_tvalid, s0_tlast, s0_tuser;
  logic       s1_tvalid, s1_tlast, s1_tuser;
  logic       tx_tready, tx_a_full;

  logic       s0_tready_a, s1_tready_a, tx_tvalid_a, tx_tlast_a, tx_tuser_a, grant_a, busy_a;
  logic [7:0] tx_tdata_a, abort_cnt_a;
  logic [15:0] frame_cnt0_a, frame_cnt1_a;
  logic       s0_tready_b, s1_tready_b, tx_tvalid_b, tx_tlast_b, tx_tuser_b, grant_b, busy_b;
  logic [7:0] tx_tdata_b, abort_cnt_b;
  logic [15:0] frame_cnt0_b, frame_cnt1_b;

  tx_frame_arbiter #(.STALL_TIMEOUT(8), .STRICT_PRIO(1'b0)) dut_a (
    .clk(clk), .rst(rst),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tuser(s0_tuser), .s0_tready(s0_tready_a),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tuser(s1_tuser), .s1_tready(s1_tready_a),
    .tx_tdata(tx_tdata_a), .tx_tvalid(tx_tvalid_a), .tx_tlast(tx_tlast_a), .tx_tuser(tx_tuser_a),
    .tx_tready(tx_tready), .tx_a_full(tx_a_full), .grant(grant_a),
    .frame_cnt0(frame_cnt0_a), .frame_cnt1(frame_cnt1_a), .abort_cnt(abort_cnt_a), .busy(busy_a)
  );

  tx_frame_arbiter #(.STALL_TIMEOUT(8), .STRICT_PRIO(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tuser(s0_tuser), .s0_tready(s0_tready_b),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tuser(s1_tuser), .s1_tready(s1_tready_b),
    .tx_tdata(tx_tdata_b), .tx_tvalid(tx_tvalid_b), .tx_tlast(tx_tlast_b), .tx_tuser(tx_tuser_b),
    .tx_tready(tx_tready), .tx_a_full(tx_a_full), .grant(grant_b),
    .frame_cnt0(frame_cnt0_b), .frame_cnt1(frame_cnt1_b), .abort_cnt(abort_cnt_b), .busy(busy_b)
  );

  bit use_strict;
  logic rdy0, rdy1, txv, txl, txu, bsy;
  logic [7:0] txd;
  assign rdy0 = use_strict ? s0_tready_b : s0_tready_a;
  assign rdy1 = use_strict ? s1_tready_b : s1_tready_a;
  assign txv  = use_strict ? tx_tvalid_b : tx_tvalid_a;
  assign txl  = use_strict ? tx_tlast_b  : tx_tlast_a;
  assign txu  = use_strict ? tx_tuser_b  : tx_tuser_a;
  assign txd  = use_strict ? tx_tdata_b  : tx_tdata_a;
  assign bsy  = use_strict ? busy_b      : busy_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] log_q[$];
  int         log_cyc[$];

  task automatic drive_srcs();
    if (q0.size() > 0) begin
      s0_tvalid = 1'b1; {s0_tuser, s0_tlast, s0_tdata} = q0[0];
    end else begin
      s0_tvalid = 1'b0; s0_tuser = 1'b0; s0_tlast = 1'b0; s0_tdata = 8'h00;
    end
    if (q1.size() > 0) begin
      s1_tvalid = 1'b1; {s1_tuser, s1_tlast, s1_tdata} = q1[0];
    end else begin
      s1_tvalid = 1'b0; s1_tuser = 1'b0; s1_tlast = 1'b0; s1_tdata = 8'h00;
    end
  endtask

  // One clock: sample handshakes mid-cycle, then advance sources after the edge
  task automatic step();
    bit h0, h1;
    @(negedge clk);
    h0 = s0_tvalid && rdy0;
    h1 = s1_tvalid && rdy1;
    if (txv && tx_tready) begin
      log_q.push_back({txu, txl, txd});
      log_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (h0) q0.delete(0);
    if (h1) q1.delete(0);
    drive_srcs();
  endtask

  task automatic push_frame(input int port, input int base, input int len, input bit with_last);
    logic [9:0] e;
    for (int i = 0; i < len; i++) begin
      e = {1'b0, (with_last && i == len - 1), 8'(base + i)};
      if (port == 0) q0.push_back(e);
      else           q1.push_back(e);
    end
    drive_srcs();
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      step();
      k++;
    end
    total++;
    if (log_q.size() < n) begin
      bad++;
      $display("FAIL %s: beats=%0d required=%0d (timeout)", name, log_q.size(), n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete();
    drive_srcs();
    step(); step();
    rst = 1'b0;
    log_q.delete(); log_cyc.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (txv !== 1'b0 || txl !== 1'b0 || txu !== 1'b0 || txd !== 8'h00) begin
      bad++; $display("FAIL reset_tx: v/l/u/d=%b%b%b/%h required 000/00", txv, txl, txu, txd); end
    total++; if (s0_tready_a !== 1'b0 || s1_tready_a !== 1'b0) begin
      bad++; $display("FAIL reset_tready: %b%b required 00", s0_tready_a, s1_tready_a); end
    total++; if (grant_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL reset_grant_busy: %b%b required 00", grant_a, busy_a); end
    total++; if (frame_cnt0_a !== 16'd0 || frame_cnt1_a !== 16'd0 || abort_cnt_a !== 8'd0) begin
      bad++; $display("FAIL reset_cnt: %0d %0d %0d required 0 0 0", frame_cnt0_a, frame_cnt1_a, abort_cnt_a); end
  endtask

  task automatic test_single_frame();
    logic [9:0] exp;
    do_reset();
    tx_tready = 1'b1;
    push_frame(0, 0, 64, 1'b1);
    wait_beats(64, 200, "single_beats");
    total++; if (busy_a !== 1'b0) begin
      bad++; $display("FAIL single_busy_drop: busy=%b required 0", busy_a); end
    for (int i = 0; i < 64 && i < log_q.size(); i++) begin
      exp = {1'b0, (i == 63), 8'(i)};
      total++; if (log_q[i] !== exp) begin
        bad++; $display("FAIL single_beat%0d: got %h required %h", i, log_q[i], exp); end
    end
    total++; if (frame_cnt0_a !== 16'd1) begin
      bad++; $display("FAIL single_cnt0: %0d required 1", frame_cnt0_a); end
  endtask

  task automatic test_round_robin();
    logic [1:0] ports [4];
    ports[0] = 2'd0; ports[1] = 2'd1; ports[2] = 2'd0; ports[3] = 2'd1;
    do_reset();
    push_frame(0, 8'h00, 4, 1'b1); push_frame(0, 8'h04, 4, 1'b1);
    push_frame(1, 8'h80, 4, 1'b1); push_frame(1, 8'h84, 4, 1'b1);
    wait_beats(16, 100, "rr_beats");
    for (int k = 0; k < 4 && 4 * k < log_q.size(); k++) begin
      total++; if (log_q[4 * k][7] !== ports[k][0]) begin
        bad++; $display("FAIL rr_grant%0d: port %b required %b", k, log_q[4 * k][7], ports[k][0]); end
    end
    for (int k = 1; k < 4 && 4 * k < log_q.size(); k++) begin
      total++; if (log_cyc[4 * k] !== log_cyc[4 * k - 1] + 2) begin
        bad++; $display("FAIL rr_gap%0d: start cyc %0d required %0d", k, log_cyc[4 * k], log_cyc[4 * k - 1] + 2); end
    end
    total++; if (frame_cnt0_a !== 16'd2 || frame_cnt1_a !== 16'd2) begin
      bad++; $display("FAIL rr_cnt: %0d/%0d required 2/2", frame_cnt0_a, frame_cnt1_a); end
  endtask

  task automatic test_strict_prio();
    use_strict = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_frame(0, 8'h10 + 2 * k, 2, 1'b1);
      push_frame(1, 8'h90 + 2 * k, 2, 1'b1);
    end
    wait_beats(12, 100, "strict_beats");
    for (int k = 0; k < 6 && 2 * k < log_q.size(); k++) begin
      total++; if (log_q[2 * k][7] !== (k < 3)) begin
        bad++; $display("FAIL strict_order%0d: port %b required %b", k, log_q[2 * k][7], (k < 3)); end
    end
    total++; if (frame_cnt0_b !== 16'd3 || frame_cnt1_b !== 16'd3) begin
      bad++; $display("FAIL strict_cnt: %0d/%0d required 3/3", frame_cnt0_b, frame_cnt1_b); end
    use_strict = 1'b0;
  endtask

  task automatic test_almost_full();
    do_reset();
    tx_a_full = 1'b1;
    push_frame(0, 8'h30, 3, 1'b1);
    repeat (5) step();
    total++; if (busy_a !== 1'b0 || txv !== 1'b0) begin
      bad++; $display("FAIL afull_block: busy=%b tvalid=%b required 0 0", busy_a, txv); end
    tx_a_full = 1'b0;
    step();
    total++; if (busy_a !== 1'b1 || txv !== 1'b1 || txd !== 8'h30) begin
      bad++; $display("FAIL afull_release: busy=%b tvalid=%b data=%h required 1 1 30", busy_a, txv, txd); end
    tx_a_full = 1'b1;
    wait_beats(3, 20, "afull_midframe_beats");
    step();
    total++; if (frame_cnt0_a !== 16'd1 || busy_a !== 1'b0) begin
      bad++; $display("FAIL afull_midframe: cnt0=%0d busy=%b required 1 0", frame_cnt0_a, busy_a); end
    tx_a_full = 1'b0;
  endtask

  task automatic test_stall_abort();
    int c10;
    int k;
    do_reset();
    push_frame(0, 8'h50, 10, 1'b0);
    wait_beats(10, 40, "stall_first10");
    c10 = (log_cyc.size() >= 10) ? log_cyc[9] : 0;
    wait_beats(11, 30, "stall_abort_beat");
    if (log_q.size() >= 11) begin
      total++; if (log_q[10] !== 10'h300) begin
        bad++; $display("FAIL stall_abort_fields: %h required 300", log_q[10]); end
      total++; if (log_cyc[10] !== c10 + 9) begin
        bad++; $display("FAIL stall_idle_cycles: abort at %0d required %0d", log_cyc[10], c10 + 9); end
    end
    total++; if (abort_cnt_a !== 8'd1 || frame_cnt0_a !== 16'd0) begin
      bad++; $display("FAIL stall_counts: abort=%0d cnt0=%0d required 1 0", abort_cnt_a, frame_cnt0_a); end
    push_frame(0, 8'h5A, 5, 1'b1);
    k = 0;
    while (q0.size() > 0 && k < 20) begin step(); k++; end
    step();
    total++; if (q0.size() !== 0 || log_q.size() !== 11 || busy_a !== 1'b0) begin
      bad++; $display("FAIL stall_drain: left=%0d beats=%0d busy=%b required 0 11 0", q0.size(), log_q.size(), busy_a); end
    total++; if (frame_cnt0_a !== 16'd0) begin
      bad++; $display("FAIL stall_drain_cnt0: %0d required 0", frame_cnt0_a); end
  endtask

  task automatic test_backpressure_reset();
    int held_bad;
    do_reset();
    tx_tready = 1'b0;
    push_frame(0, 8'hA0, 4, 1'b1);
    step();
    held_bad = 0;
    repeat (2000) begin
      step();
      if (txv !== 1'b1 || txd !== 8'hA0 || txl !== 1'b0 || busy_a !== 1'b1) held_bad++;
    end
    total++; if (held_bad !== 0 || abort_cnt_a !== 8'd0) begin
      bad++; $display("FAIL bp_hold: unstable=%0d abort=%0d required 0 0", held_bad, abort_cnt_a); end
    tx_tready = 1'b1;
    wait_beats(4, 20, "bp_release_beats");
    step();
    total++; if (log_q.size() < 1 || log_q[0] !== 10'h0A0 || frame_cnt0_a !== 16'd1) begin
      bad++; $display("FAIL bp_complete: cnt0=%0d beats=%0d required 1 4", frame_cnt0_a, log_q.size()); end
    // Reset in the middle of a second frame
    push_frame(0, 8'h40, 8, 1'b1);
    wait_beats(7, 20, "rst_mid_beats");
    rst = 1'b1;
    step();
    total++; if (busy_a !== 1'b0 || txv !== 1'b0 || s0_tready_a !== 1'b0 || grant_a !== 1'b0) begin
      bad++; $display("FAIL rst_mid_state: busy=%b tvalid=%b tready=%b grant=%b required 0000", busy_a, txv, s0_tready_a, grant_a); end
    total++; if (frame_cnt0_a !== 16'd0 || abort_cnt_a !== 8'd0) begin
      bad++; $display("FAIL rst_mid_cnt: cnt0=%0d abort=%0d required 0 0", frame_cnt0_a, abort_cnt_a); end
    q0.delete();
    drive_srcs();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; use_strict = 1'b0;
    tx_tready = 1'b1; tx_a_full = 1'b0;
    drive_srcs();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_strict_prio();
    test_almost_full();
    test_stall_abort();
    test_backpressure_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
